// File: rtl/aes_iter_cipher_if.sv
// Host-side handshake bundle for aes_iter_cipher: start/ready/done plus
// plaintext, key and ciphertext buses. Width of Key follows KEY_BITS.
interface aes_iter_cipher_if #(
   parameter int KEY_BITS = 128
);
   logic                start;
   logic [127:0]        Plain_Text;
   logic [KEY_BITS-1:0] Key;
   logic                ready;
   logic                done;
   logic [127:0]        Cipher_Text;

   modport master (
      output start, Plain_Text, Key,
      input  ready, done, Cipher_Text
   );

   modport slave (
      input  start, Plain_Text, Key,
      output ready, done, Cipher_Text
   );
endinterface

// File: rtl/aes_iter_cipher.sv
// Iterative AES encryption core (AES-128 / AES-256), one round per clock,
// key schedule expanded on the fly alongside the rounds.
// Optional build macro AES_ITER_DBG_EN adds dbg_round / dbg_state outputs.
module aes_iter_cipher #(
   parameter int KEY_BITS = 128
) (
   input  logic              clk,
   input  logic              nrst,
   aes_iter_cipher_if.slave  bus
`ifdef AES_ITER_DBG_EN
   ,
   output logic [3:0]        dbg_round,
   output logic [127:0]      dbg_state
`endif
);

   localparam logic [3:0] NR = (KEY_BITS == 256) ? 4'd14 : 4'd10;

   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   typedef enum logic {IDLE, RUN} fsm_e;

   fsm_e                fsm_q, fsm_d;
   logic [3:0]          round_q, round_d;
   logic [127:0]        state_q, state_d;
   logic [KEY_BITS-1:0] key_q, key_d;
   logic [127:0]        ct_q, ct_d;
   logic                done_q, done_d;

   logic [127:0]        sr_out, mc_out, round_out, round_key;
   logic [KEY_BITS-1:0] key_next;

   function automatic logic [7:0] sbox(input logic [7:0] x);
      int unsigned idx;
      idx = 32'(x);
      return SBOX[2047 - 8*idx -: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Byte k of the block sits at bits [127-8k -: 8]; byte r+4c is state[r][c]
   function automatic logic [127:0] sub_shift(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int unsigned c = 0; c < 4; c++)
         for (int unsigned r = 0; r < 4; r++)
            o[127 - 8*(4*c + r) -: 8] = sbox(s[127 - 8*(4*((c + r) % 4) + r) -: 8]);
      return o;
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int unsigned c = 0; c < 4; c++) begin
         a0 = s[127 - 32*c -: 8];
         a1 = s[119 - 32*c -: 8];
         a2 = s[111 - 32*c -: 8];
         a3 = s[103 - 32*c -: 8];
         o[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         o[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         o[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         o[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return o;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] i);
      case (i)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   // Four new schedule words from the oldest four words and the transformed temp word
   function automatic logic [127:0] expand4(input logic [127:0] old4, input logic [31:0] t);
      logic [31:0] n0, n1, n2, n3;
      n0 = old4[127:96] ^ t;
      n1 = old4[95:64]  ^ n0;
      n2 = old4[63:32]  ^ n1;
      n3 = old4[31:0]   ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   generate
      if (KEY_BITS == 256) begin : g_k256
         logic [31:0] temp_w;
         // Window holds w[4(r-1)..4(r-1)+7]; round key r is its lower (newer) half
         always_comb begin
            if (round_q[0])
               temp_w = sub_word(rot_word(key_q[31:0])) ^ {rcon((round_q + 4'd1) >> 1), 24'h0};
            else
               temp_w = sub_word(key_q[31:0]);
            key_next  = {key_q[127:0], expand4(key_q[255:128], temp_w)};
            round_key = key_q[127:0];
         end
      end else if (KEY_BITS == 128) begin : g_k128
         logic [31:0] temp_w;
         // Window holds round key r-1; its expansion is round key r
         always_comb begin
            temp_w    = sub_word(rot_word(key_q[31:0])) ^ {rcon(round_q), 24'h0};
            key_next  = expand4(key_q, temp_w);
            round_key = key_next;
         end
      end else begin : g_bad_key_bits
         $error("aes_iter_cipher: KEY_BITS must be 128 or 256");
      end
   endgenerate

   assign sr_out    = sub_shift(state_q);
   assign mc_out    = mix_columns(sr_out);
   assign round_out = ((round_q == NR) ? sr_out : mc_out) ^ round_key;

   // Next-state logic: accept in IDLE, one round per cycle in RUN
   always_comb begin
      fsm_d   = fsm_q;
      round_d = round_q;
      state_d = state_q;
      key_d   = key_q;
      ct_d    = ct_q;
      done_d  = 1'b0;
      case (fsm_q)
         IDLE: begin
            if (bus.start) begin
               state_d = bus.Plain_Text ^ bus.Key[KEY_BITS-1 -: 128];
               key_d   = bus.Key;
               round_d = 4'd1;
               fsm_d   = RUN;
            end
         end
         RUN: begin
            state_d = round_out;
            key_d   = key_next;
            if (round_q == NR) begin
               ct_d    = round_out;
               done_d  = 1'b1;
               round_d = '0;
               fsm_d   = IDLE;
            end else begin
               round_d = round_q + 4'd1;
            end
         end
         default: fsm_d = IDLE;
      endcase
   end

   // State registers with asynchronous abort
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         fsm_q   <= IDLE;
         round_q <= '0;
         state_q <= '0;
         key_q   <= '0;
         ct_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         fsm_q   <= fsm_d;
         round_q <= round_d;
         state_q <= state_d;
         key_q   <= key_d;
         ct_q    <= ct_d;
         done_q  <= done_d;
      end
   end

   assign bus.ready       = (fsm_q == IDLE);
   assign bus.done        = done_q;
   assign bus.Cipher_Text = ct_q;

`ifdef AES_ITER_DBG_EN
   assign dbg_round = round_q;
   assign dbg_state = state_q;
`endif

endmodule
